player_missile_pool: RTL

- Parametrised player-missile engine for the VGA Space Invaders peripheral; generalises the fixed 8-missile player logic to NUM_MISSILES slots.
- Adds fire edge detection, lowest-free-slot allocation, inter-shot cooldown, and external hit/kill from the collision logic.
- Sits between the button/GPIO interface and the pixel mux; outputs per-pixel missile activity and 4-bit pixel data.

---
 rtl/player_missile_pool.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/player_missile_pool.sv
// -----------------------------------------------------------------------------
// player_missile_pool
//   Player missile engine for the VGA Space Invaders peripheral. Keeps a pool
//   of NUM_MISSILES slots, each rising STEP rows per motion tick. A debounced
//   fire level is edge-detected and held as a pending shot until the next
//   tick, where it spawns into the lowest free slot, subject to an inter-shot
//   cooldown. The collision logic can kill any slot on any cycle.
//
// Ports
//   clk, rst         pixel clock, asynchronous active-low reset
//   pixel_row/column current scan position
//   player_col       player left column (gun barrel at +GUN_OFFSET)
//   fire             debounced fire button level
//   hit_valid/idx    single-cycle kill request for one slot
//   missile_active   per-slot pixel hit at the scan position
//   missile_output   4'hF when any slot covers the scan position
//   live/live_count  in-flight flags and their population count
//   tick             one-cycle motion strobe, period TICK_DIV clocks
//   fire_accepted    one-cycle pulse when a missile spawns
// -----------------------------------------------------------------------------

// One missile slot: position state plus its pixel comparator.
module pm_slot #(
    parameter int COORD_W     = 12,
    parameter int STEP        = 2,
    parameter int MISSILE_LEN = 3,
    parameter int SPAWN_ROW   = 460
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               spawn,
    input  logic               hit,
    input  logic [COORD_W-1:0] spawn_col,
    input  logic [COORD_W-1:0] pixel_row,
    input  logic [COORD_W-1:0] pixel_column,
    output logic               live,
    output logic               active
);
    localparam int RW = COORD_W + 1;

    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic [RW-1:0]      row_end;

    // Kill outranks spawn and motion: a slot hit while being spawned stays
    // dead, and a live slot that is hit does not also move.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live <= 1'b0;
            row  <= COORD_W'(SPAWN_ROW);
            col  <= '0;
        end else if (hit) begin
            live <= 1'b0;
            row  <= COORD_W'(SPAWN_ROW);
        end else if (spawn) begin
            live <= 1'b1;
            row  <= COORD_W'(SPAWN_ROW);
            col  <= spawn_col;
        end else if (tick && live) begin
            if (row < COORD_W'(STEP)) begin
                live <= 1'b0;
                row  <= COORD_W'(SPAWN_ROW);
            end else begin
                row <= row - COORD_W'(STEP);
            end
        end
    end

    // One extra bit so a missile near the top of the coordinate range does
    // not wrap its lower edge.
    assign row_end = {1'b0, row} + RW'(MISSILE_LEN);

    assign active = live
                 && (pixel_column == col)
                 && (pixel_row >= row)
                 && ({1'b0, pixel_row} < row_end);
endmodule

module player_missile_pool #(
    parameter int NUM_MISSILES   = 8,
    parameter int COORD_W        = 12,
    parameter int TICK_DIV       = 500000,
    parameter int STEP           = 2,
    parameter int MISSILE_LEN    = 3,
    parameter int SPAWN_ROW      = 460,
    parameter int GUN_OFFSET     = 8,
    parameter int COOLDOWN_TICKS = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [COORD_W-1:0]                    pixel_row,
    input  logic [COORD_W-1:0]                    pixel_column,
    input  logic [COORD_W-1:0]                    player_col,
    input  logic                                  fire,
    input  logic                                  hit_valid,
    input  logic [((NUM_MISSILES > 1) ? $clog2(NUM_MISSILES) : 1)-1:0] hit_idx,
    output logic [NUM_MISSILES-1:0]               missile_active,
    output logic [3:0]                            missile_output,
    output logic [NUM_MISSILES-1:0]               live,
    output logic [$clog2(NUM_MISSILES+1)-1:0]     live_count,
    output logic                                  tick,
    output logic                                  fire_accepted
);
    localparam int IW  = (NUM_MISSILES > 1) ? $clog2(NUM_MISSILES) : 1;
    localparam int LCW = $clog2(NUM_MISSILES + 1);
    localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CDW = (COOLDOWN_TICKS > 0) ? $clog2(COOLDOWN_TICKS + 1) : 1;

    typedef struct packed {
        logic                    vld;
        logic [NUM_MISSILES-1:0] sel;
        logic [COORD_W-1:0]      col;
    } spawn_req_t;

    logic [TW-1:0]           tick_cnt;
    logic [CDW-1:0]          cooldown;
    logic                    fire_q;
    logic                    pending;
    logic                    fire_rise;
    logic [NUM_MISSILES-1:0] free_oh;
    logic                    any_free;
    logic [NUM_MISSILES-1:0] hit_sel;
    spawn_req_t              spawn_req;

    // ---------------- motion tick ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick     <= (tick_cnt == TW'(TICK_DIV - 1));
            tick_cnt <= (tick_cnt == TW'(TICK_DIV - 1)) ? '0 : tick_cnt + 1'b1;
        end
    end

    // ---------------- fire edge / pending shot ----------------
    assign fire_rise = fire & ~fire_q;

    // The tick consumes the pending shot whether or not it spawns. An edge
    // landing exactly on the tick cycle is carried to the following tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fire_q  <= 1'b0;
            pending <= 1'b0;
        end else begin
            fire_q <= fire;
            if (tick)
                pending <= fire_rise;
            else if (fire_rise)
                pending <= 1'b1;
        end
    end

    // ---------------- slot allocation ----------------
    // Lowest-index free slot, from pre-tick live; slots freed this tick only
    // become visible here on the next one.
    always_comb begin
        free_oh  = '0;
        any_free = 1'b0;
        for (int i = 0; i < NUM_MISSILES; i++) begin
            if (!live[i] && !any_free) begin
                free_oh[i] = 1'b1;
                any_free   = 1'b1;
            end
        end
    end

    always_comb begin
        spawn_req.vld = tick && pending && (cooldown == '0) && any_free;
        spawn_req.sel = spawn_req.vld ? free_oh : '0;
        spawn_req.col = player_col + COORD_W'(GUN_OFFSET);
    end

    always_comb begin
        hit_sel = '0;
        for (int i = 0; i < NUM_MISSILES; i++)
            hit_sel[i] = hit_valid && (hit_idx == IW'(i));
    end

    // ---------------- cooldown / accept strobe ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cooldown      <= '0;
            fire_accepted <= 1'b0;
        end else begin
            fire_accepted <= spawn_req.vld;
            if (spawn_req.vld)
                cooldown <= CDW'(COOLDOWN_TICKS);
            else if (tick && (cooldown != '0))
                cooldown <= cooldown - 1'b1;
        end
    end

    // ---------------- slot array ----------------
    for (genvar g = 0; g < NUM_MISSILES; g++) begin : g_slot
        pm_slot #(
            .COORD_W     (COORD_W),
            .STEP        (STEP),
            .MISSILE_LEN (MISSILE_LEN),
            .SPAWN_ROW   (SPAWN_ROW)
        ) u_slot (
            .clk          (clk),
            .rst          (rst),
            .tick         (tick),
            .spawn        (spawn_req.sel[g]),
            .hit          (hit_sel[g]),
            .spawn_col    (spawn_req.col),
            .pixel_row    (pixel_row),
            .pixel_column (pixel_column),
            .live         (live[g]),
            .active       (missile_active[g])
        );
    end

    // ---------------- outputs ----------------
    assign missile_output = (|missile_active) ? 4'hF : 4'h0;

    always_comb begin
        live_count = '0;
        for (int i = 0; i < NUM_MISSILES; i++)
            live_count = live_count + LCW'(live[i]);
    end
endmodule
